// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Accumulator-machine sequencer in front of a combinational 2-bit-select ALU
//   (00 clear, 01 A+B, 10 A-B, 11 pass A). It takes one command at a time over
//   a valid/ready handshake, drives the ALU operands and select, and writes the
//   ALU result back into its accumulator. MUL is one clear followed by N adds
//   of the multiplicand, which is the accumulator value at accept time.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      command can be accepted (IDLE only)
//   cmd_op      in   3      000 NOP, 001 CLR, 010 ADD, 011 SUB, 100 LOAD, 101 MUL, 11x illegal
//   cmd_data    in   WIDTH  operand, or repeat count in [CNT_W-1:0] for MUL
//   alu_a       out  WIDTH  ALU operand A
//   alu_b       out  WIDTH  ALU operand B
//   alu_sel     out  2      ALU select
//   alu_result  in   WIDTH  ALU output
//   acc_out     out  WIDTH  accumulator (registered)
//   busy        out  1      any state other than IDLE
//   done        out  1      one-cycle pulse, command complete and acc_out updated
//   err         out  1      one-cycle pulse alongside done for an illegal opcode
//   state_dbg   out  3      current FSM state encoding, for observation only
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high; cmd_op/cmd_data are sampled on that edge only and
// ignored at every other edge, even if cmd_valid stays high.

module alu_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] acc_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state_dbg
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    localparam logic [1:0] SEL_CLR  = 2'b00;
    localparam logic [1:0] SEL_ADD  = 2'b01;
    localparam logic [1:0] SEL_SUB  = 2'b10;
    localparam logic [1:0] SEL_PASS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_MUL_CLR = 3'd2,
        S_MUL_ADD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             err_q;

    logic             op_illegal;
    logic             op_writes_acc;

    assign op_illegal    = op_q[2] & op_q[1];
    assign op_writes_acc = (op_q == OP_CLR) || (op_q == OP_ADD) ||
                           (op_q == OP_SUB) || (op_q == OP_LOAD);

    // ALU drive is decoded from registered state only, so the ALU output is
    // stable for the whole cycle and is captured into acc at its end.
    always_comb begin
        alu_sel = SEL_PASS;
        alu_a   = acc_q;
        alu_b   = '0;
        unique case (state_q)
            S_EXEC: begin
                unique case (op_q)
                    OP_CLR:  alu_sel = SEL_CLR;
                    OP_ADD:  begin alu_sel = SEL_ADD; alu_b = data_q; end
                    OP_SUB:  begin alu_sel = SEL_SUB; alu_b = data_q; end
                    OP_LOAD: alu_a   = data_q;
                    default: alu_sel = SEL_PASS;   // NOP / illegal hold acc
                endcase
            end
            S_MUL_CLR: alu_sel = SEL_CLR;
            S_MUL_ADD: begin alu_sel = SEL_ADD; alu_b = mcand_q; end
            default:   alu_sel = SEL_PASS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        data_q  <= cmd_data;
                        state_q <= (cmd_op == OP_MUL) ? S_MUL_CLR : S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_writes_acc) begin
                        acc_q <= alu_result;
                    end
                    done_q  <= 1'b1;
                    err_q   <= op_illegal;
                    state_q <= S_DONE;
                end
                S_MUL_CLR: begin
                    // acc has not changed since accept, so it is the multiplicand.
                    mcand_q <= acc_q;
                    cnt_q   <= data_q[CNT_W-1:0];
                    acc_q   <= alu_result;
                    if (data_q[CNT_W-1:0] != '0) begin
                        state_q <= S_MUL_ADD;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_MUL_ADD: begin
                    acc_q <= alu_result;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // cnt holds the adds still to do including this one.
                    if (cnt_q == CNT_W'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign acc_out   = acc_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] acc_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // reference accumulator of the command-level model
  logic [WIDTH-1:0] acc_m;

  alu_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .acc_out    (acc_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // the combinational ALU the controller sits in front of
  always_comb begin
    case (alu_sel)
      2'b00:   alu_result = '0;
      2'b01:   alu_result = alu_a + alu_b;
      2'b10:   alu_result = alu_a - alu_b;
      default: alu_result = alu_a;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // command-level reference: result and cycle in which done must appear
  task automatic model(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       output logic [WIDTH-1:0] res, output int lat, output logic e);
    int unsigned n;
    n   = data & 32'hFF;
    lat = 2;
    e   = 1'b0;
    res = acc_m;
    case (op)
      3'd1: res = '0;
      3'd2: res = WIDTH'(acc_m + data);
      3'd3: res = WIDTH'(acc_m - data);
      3'd4: res = data;
      3'd5: begin res = WIDTH'(acc_m * n); lat = n + 2; end
      3'd6, 3'd7: e = 1'b1;
      default: res = acc_m;
    endcase
  endtask

  // driver: issue one command, follow it to done, check result/latency/pulses
  task automatic do_cmd(input string tag, input logic [2:0] op,
                        input logic [WIDTH-1:0] data, input bit hold_junk);
    logic [WIDTH-1:0] exp_acc;
    int               exp_lat;
    logic             exp_err;
    int               cyc;
    int               w;
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    check({tag, "_ready"}, cmd_ready, 1'b1);
    check({tag, "_idle_sel"}, alu_sel, 2'b11);
    check({tag, "_idle_a"}, alu_a, acc_m);
    model(op, data, exp_acc, exp_lat, exp_err);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();                       // accepting edge; now in cycle 1
    cyc = 1;
    if (!hold_junk) cmd_valid = 1'b0;
    while (!done && cyc < 400) begin
      if (hold_junk) begin
        cmd_op   = 3'($urandom_range(0, 7));
        cmd_data = WIDTH'($urandom);
      end
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_acc"}, acc_out, exp_acc);
    check({tag, "_busy_at_done"}, busy, 1'b1);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_err_pulse"}, err, 1'b0);
    check({tag, "_back_idle"}, cmd_ready, 1'b1);
    acc_m = exp_acc;
  endtask

  initial begin
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
    acc_m     = '0;

    // reset state
    tick();
    tick();
    check("rst_acc", acc_out, 16'h0000);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sel", alu_sel, 2'b11);
    rst = 1'b0;
    tick();
    check("rel_acc", acc_out, 16'h0000);
    check("rel_ready", cmd_ready, 1'b1);
    check("rel_busy", busy, 1'b0);
    check("rel_done", done, 1'b0);

    // directed
    do_cmd("load1234", 3'd4, 16'h1234, 0);
    do_cmd("add0010", 3'd2, 16'h0010, 0);
    check("sum_1244", acc_out, 16'h1244);
    do_cmd("load3", 3'd4, 16'h0003, 0);
    do_cmd("sub5", 3'd3, 16'h0005, 0);
    check("sub_wrap", acc_out, 16'hFFFE);
    do_cmd("loadffff", 3'd4, 16'hFFFF, 0);
    do_cmd("addffff", 3'd2, 16'hFFFF, 0);
    check("add_wrap", acc_out, 16'hFFFE);
    do_cmd("load7", 3'd4, 16'h0007, 0);
    do_cmd("mul5", 3'd5, 16'h0005, 0);
    check("mul_35", acc_out, 16'h0023);
    do_cmd("mul0", 3'd5, 16'h0000, 0);
    check("mul0_zero", acc_out, 16'h0000);
    do_cmd("load_a5", 3'd4, 16'h00A5, 0);
    do_cmd("mul3_junk", 3'd5, 16'hFF03, 1);     // only low byte counts
    do_cmd("add_junk", 3'd2, 16'h0101, 1);
    do_cmd("illegal110", 3'd6, 16'h5555, 0);
    do_cmd("illegal111", 3'd7, 16'hAAAA, 1);
    do_cmd("nop", 3'd0, 16'h1111, 0);
    do_cmd("clr", 3'd1, 16'h2222, 0);
    check("clr_zero", acc_out, 16'h0000);

    // randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_data = WIDTH'($urandom);
      if (r_op == 3'd5) r_data[7:0] = 8'($urandom_range(0, 12));
      do_cmd("rand", r_op, r_data, bit'($urandom_range(0, 1)));
    end

    // reset in the middle of a long MUL
    do_cmd("load9", 3'd4, 16'h0009, 0);
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_data  = 16'd200;
    tick();
    cmd_valid = 1'b0;
    repeat (50) tick();
    check("mid_mul_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_acc", acc_out, 16'h0000);
    check("abort_done", done, 1'b0);
    check("abort_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_done", done, 1'b0);
      tick();
    end
    acc_m = '0;
    do_cmd("post_abort_add", 3'd2, 16'h0042, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
